// File: rtl/pipe_rr_arb.sv
// pipe_rr_arb: round-robin arbiter in front of one registered valid/ready stage.
// N requesters compete for the stage. A winner may keep it for a burst of up
// to MAX_BURST beats; the burst ends early when the winner flags last.
// Each output beat is tagged with the index of the requester it came from.
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_i        asynchronous active-high reset
//   req_data_i   N*WIDTH requester data, requester k at [k*WIDTH +: WIDTH]
//   req_vld_i    N requester valid
//   req_last_i   N requester last-beat-of-burst flag
//   req_rdy_o    N per-requester ready (one-hot or zero)
//   data_o       registered output data
//   data_id_o    registered source index of data_o
//   data_last_o  registered burst-end flag
//   data_vld_o   registered output valid
//   data_rdy_i   downstream ready

// Per-requester ready decode: requester IDX is ready when it is the
// selected source and the stage can take a beat.
module pipe_rr_arb_lane #(
  parameter int IDW = 1,
  parameter int IDX = 0
) (
  input  logic [IDW-1:0] sel,
  input  logic           go,
  output logic           rdy
);
  assign rdy = go & (sel == IDW'(IDX));
endmodule

module pipe_rr_arb #(
  parameter int WIDTH     = 32,
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N*WIDTH-1:0]   req_data_i,
  input  logic [N-1:0]         req_vld_i,
  input  logic [N-1:0]         req_last_i,
  output logic [N-1:0]         req_rdy_o,
  output logic [WIDTH-1:0]     data_o,
  output logic [((N>1)?$clog2(N):1)-1:0] data_id_o,
  output logic                 data_last_o,
  output logic                 data_vld_o,
  input  logic                 data_rdy_i
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]               state;
  logic [IDW-1:0]           ptr, owner;
  logic [CW-1:0]            cnt;

  logic [N-1:0][WIDTH-1:0]  req_data;
  logic                     stg_rdy;
  logic [IDW-1:0]           gnt;
  logic                     found;
  logic [IDW-1:0]           sel;
  logic                     sel_vld;
  logic                     sel_last;
  logic                     go;
  logic [CW-1:0]            beat, beat_nxt;
  logic                     ends;
  logic [IDW-1:0]           ptr_nxt;

  assign req_data = req_data_i;

  // Stage accepts a new beat when empty or when the current one drains.
  assign stg_rdy = data_rdy_i | ~data_vld_o;

  // Rotating priority search starting at ptr.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int             j;
      logic [IDW-1:0] idx;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = j[IDW-1:0];
      if (!found && req_vld_i[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // While locked the owner is the only candidate, valid or not.
  assign sel      = (state == ST_LOCK) ? owner : gnt;
  assign sel_vld  = (state == ST_LOCK) ? req_vld_i[owner] : found;
  assign sel_last = req_last_i[sel];

  // go doubles as "transfer this cycle": the selected requester is valid
  // and its ready is driven high.
  assign go = ~rst_i & sel_vld & stg_rdy;

  // Beat index within the burst; first beat of a grant is index 0.
  assign beat     = (state == ST_LOCK) ? cnt : '0;
  assign beat_nxt = beat + 1'b1;
  assign ends     = sel_last | (beat_nxt == CW'(MAX_BURST));
  assign ptr_nxt  = (sel == IDW'(N - 1)) ? '0 : sel + 1'b1;

  for (genvar k = 0; k < N; k++) begin : g_lane
    pipe_rr_arb_lane #(.IDW(IDW), .IDX(k)) u_lane (
      .sel (sel),
      .go  (go),
      .rdy (req_rdy_o[k])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      data_o      <= '0;
      data_id_o   <= '0;
      data_last_o <= 1'b0;
      data_vld_o  <= 1'b0;
    end else if (go) begin
      data_o      <= req_data[sel];
      data_id_o   <= sel;
      data_last_o <= ends;
      data_vld_o  <= 1'b1;
      if (ends) begin
        state <= ST_IDLE;
        ptr   <= ptr_nxt;
        cnt   <= '0;
      end else begin
        state <= ST_LOCK;
        owner <= sel;
        cnt   <= beat_nxt;
      end
    end else if (stg_rdy) begin
      // Drained with nothing new: emit a bubble, payload holds.
      data_vld_o <= 1'b0;
    end
  end
endmodule
